snes_bus_strobe: RTL and testbench
==================================

# snes_bus_strobe

Front-end conditioning stage for the SNES cartridge bus. It synchronizes and glitch-filters the raw SNES control lines into the `clk` domain and captures address and data. It emits the single-cycle `SNES_rd_strobe`, `SNES_wr_strobe`, `SNES_cycle_start` and `SNES_reset_strobe` pulses, plus the `pad_latch` and `snes_ajr` status bits, that the hook/cheat engine and other bus consumers sit directly downstream of.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per control line (≥2).
- `FILT`, 3: consecutive equal synchronized samples required before a filtered line changes (1..15).
- `RD_DELAY`, 2: clocks from filtered /RD fall to `SNES_rd_strobe` (address settle time, 0..7).
- `clk` in 1: system clock; sole clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `SNES_CPU_CLK_in` in 1: raw CPU clock.
- `SNES_READ_in` in 1: raw /RD, active low.
- `SNES_WRITE_in` in 1: raw /WR, active low.
- `SNES_RESET_in` in 1: raw console /RESET, active low.
- `SNES_ADDR_in` in 24: raw A-bus address.
- `SNES_PA_in` in 8: raw B-bus address.
- `SNES_DATA_in` in 8: raw data bus.
- `SNES_ADDR` out 24: captured address, valid on every strobe cycle.
- `SNES_PA` out 8: captured B-bus address, captured alongside `SNES_ADDR`.
- `SNES_DATA` out 8: last data sampled during /WR low, valid on `SNES_wr_strobe`.
- `SNES_rd_strobe` out 1: one-clock pulse per read access.
- `SNES_wr_strobe` out 1: one-clock pulse per write access, at end of write.
- `SNES_cycle_start` out 1: one-clock pulse per CPU clock rising edge.
- `SNES_reset_strobe` out 1: one-clock pulse on console reset release.
- `SNES_reset_active` out 1: filtered /RESET asserted.
- `pad_latch` out 1: complete manual joypad latch seen since last reset.
- `snes_ajr` out 1: auto-joypad-read enable, bit 0 of last $4200 write.

## Operation
- Sync chains reset to 1 for active-low lines and to 0 for CPU_CLK. Address, PA and data each pass through 2 flops with no filter.
- Filter per line:
  - a 4-bit counter increments while the synchronized value differs from the filtered value, and clears when they match;
  - at count FILT−1 with a still-differing sample, the filtered value flips and the counter clears.
- `SNES_cycle_start`: filtered CPU_CLK 0→1 edge. `SNES_ADDR`/`SNES_PA` load on the same clock.
- Read FSM, states IDLE → WAIT → DONE:
  - filtered /RD fall moves IDLE→WAIT and loads a delay counter with RD_DELAY;
  - in WAIT, the counter decrements; at 0, pulse `SNES_rd_strobe`, load ADDR/PA, go to DONE;
  - /RD rising while in WAIT aborts to IDLE with no strobe;
  - DONE→IDLE on /RD rise;
  - RD_DELAY=0 strobes on the edge clock.
- Write: while filtered /WR is low, `SNES_DATA` and the pending ADDR/PA load every clock. On filtered /WR rise, pulse `SNES_wr_strobe` with the outputs holding the final in-write sample.
- Simultaneous strobes on one clock are all emitted. ADDR capture priority is rd > wr > cycle_start.
- Decode is applied on `SNES_wr_strobe` with `SNES_ADDR[22]==0` (banks $00-$3F, $80-$BF):
  - `[15:0]==$4200`: `snes_ajr` ← DATA[0];
  - `[15:0]==$4016`: DATA[0]=1 arms the latch flag; a later DATA[0]=0 while armed sets `pad_latch` and disarms.
- Reset:
  - `SNES_reset_active` = inverted filtered /RESET;
  - filtered /RESET 0→1 pulses `SNES_reset_strobe` and clears `snes_ajr`, `pad_latch` and the arm flag on the same clock;
  - while reset is active, rd/wr strobes are suppressed and the FSM is held in IDLE.
- `rst_n` low: all outputs 0, filtered lines inactive (/RD,/WR,/RESET = 1, CPU_CLK = 0), FSM IDLE, counters 0. No strobe is produced on `rst_n` release, even if the raw lines are active at that time.

## Timing
- Pin edge → filtered edge: SYNC_STAGES+FILT clocks (5 at defaults).
- /RD pin fall → `SNES_rd_strobe`: SYNC_STAGES+FILT+RD_DELAY clocks (7 at defaults).
- /WR pin rise → `SNES_wr_strobe`: SYNC_STAGES+FILT clocks.
- `snes_ajr`/`pad_latch` update on the clock after `SNES_wr_strobe`. `SNES_reset_strobe` fires SYNC_STAGES+FILT clocks after /RESET release.
- Pulses are exactly one clock; there is at most one rd and one wr strobe per bus access.
- Minimum accepted pulse width: FILT clocks of stable synchronized level.

## Structure
- Package `snes_bus_pkg`: `SNES_REG_JOYSER0`=16'h4016, `SNES_REG_NMITIMEN`=16'h4200, read FSM state enum, default parameter constants.
- Sub-module `snes_sig_filter` (sync chain + filter + rise/fall pulses), instantiated for CPU_CLK, /RD, /WR and /RESET.

## Test plan
- Reset: hold `rst_n` low with raw /RD low → all outputs 0. Release → no `SNES_rd_strobe`.
- Read: ADDR_in=$00FFEB, /RD low for 20 clk → exactly one `SNES_rd_strobe` 7 clk after the fall, with `SNES_ADDR`=$00FFEB.
- Glitch/abort: /RD low 2 clk → no strobe. /RD low 6 clk (released during WAIT) → no strobe.
- Register writes:
  - write $01 to $004200 → `snes_ajr`=1;
  - write $01 then $00 to $804016 → `pad_latch`=1;
  - same sequence to $404016 → unchanged.
- Console reset: /RESET low 50 clk → `SNES_reset_active`=1 and no rd/wr strobes. Release → one `SNES_reset_strobe` 5 clk later, with `snes_ajr`=`pad_latch`=0.
- Cycle/push pattern: CPU_CLK toggling with four /WR pulses at PA $FF,$FE,$FD,$FC → one `SNES_cycle_start` per rising edge and four `SNES_wr_strobe` pulses with matching `SNES_PA`.

Source files
------------

// File: rtl/snes_bus_pkg.sv
// Shared constants, line indices and read-FSM state type for the SNES bus front end.
package snes_bus_pkg;

  localparam logic [15:0] SNES_REG_JOYSER0  = 16'h4016;
  localparam logic [15:0] SNES_REG_NMITIMEN = 16'h4200;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT        = 3;
  localparam int DEF_RD_DELAY    = 2;

  // Control-line lanes, one filter instance each
  localparam int NUM_LINES = 4;
  localparam int LN_CLK    = 0;
  localparam int LN_RD     = 1;
  localparam int LN_WR     = 2;
  localparam int LN_RST    = 3;
  localparam logic [NUM_LINES-1:0] LINE_RST = 4'b1110;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_DONE
  } rd_state_e;

  // System registers decode only in banks $00-$3F/$80-$BF.
  function automatic logic is_sys_reg(input logic [23:0] a, input logic [15:0] r);
    return !a[22] && (a[15:0] == r);
  endfunction

endpackage

// File: rtl/snes_bus_strobe_if.sv
// Raw SNES cartridge-bus pins in, conditioned address/data and strobes out.
interface snes_bus_strobe_if;
  logic        SNES_CPU_CLK_in;
  logic        SNES_READ_in;
  logic        SNES_WRITE_in;
  logic        SNES_RESET_in;
  logic [23:0] SNES_ADDR_in;
  logic [7:0]  SNES_PA_in;
  logic [7:0]  SNES_DATA_in;

  logic [23:0] SNES_ADDR;
  logic [7:0]  SNES_PA;
  logic [7:0]  SNES_DATA;
  logic        SNES_rd_strobe;
  logic        SNES_wr_strobe;
  logic        SNES_cycle_start;
  logic        SNES_reset_strobe;
  logic        SNES_reset_active;
  logic        pad_latch;
  logic        snes_ajr;

  modport master (
    output SNES_CPU_CLK_in, SNES_READ_in, SNES_WRITE_in, SNES_RESET_in,
           SNES_ADDR_in, SNES_PA_in, SNES_DATA_in,
    input  SNES_ADDR, SNES_PA, SNES_DATA, SNES_rd_strobe, SNES_wr_strobe,
           SNES_cycle_start, SNES_reset_strobe, SNES_reset_active, pad_latch, snes_ajr
  );

  modport slave (
    input  SNES_CPU_CLK_in, SNES_READ_in, SNES_WRITE_in, SNES_RESET_in,
           SNES_ADDR_in, SNES_PA_in, SNES_DATA_in,
    output SNES_ADDR, SNES_PA, SNES_DATA, SNES_rd_strobe, SNES_wr_strobe,
           SNES_cycle_start, SNES_reset_strobe, SNES_reset_active, pad_latch, snes_ajr
  );
endinterface

// File: rtl/snes_sig_filter.sv
// One control line: sync chain, FILT-sample glitch filter, and edge flags.
// o_rise/o_fall are high on the clock where o_level is about to flip.
module snes_sig_filter #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT        = 3,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES:0]   r_vld_pipe;
    logic [3:0]             r_cnt;
    logic                   r_filt;
    logic                   w_s, w_flip;

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_flip  = r_vld_pipe[SYNC_STAGES] && (w_s != r_filt) && (r_cnt == 4'(FILT - 1));
    assign o_level = r_filt;
    assign o_rise  = w_flip && w_s;
    assign o_fall  = w_flip && !w_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= {SYNC_STAGES{RST_VAL}};
            r_vld_pipe <= '0;
            r_cnt      <= '0;
            r_filt     <= RST_VAL;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_vld_pipe <= {r_vld_pipe[SYNC_STAGES-1:0], 1'b1};
            // Until the chain holds real pin samples, follow them silently so a
            // line already active at reset release never produces an edge.
            if (!r_vld_pipe[SYNC_STAGES]) begin
                r_filt <= w_s;
                r_cnt  <= '0;
            end else if (w_s == r_filt) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_filt <= w_s;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end
endmodule

// File: rtl/snes_bus_strobe.sv
// SNES bus front end: filtered control lines, address/data capture, access strobes
// and the $4200/$4016 status bits used by downstream bus consumers.
module snes_bus_strobe
    import snes_bus_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT        = DEF_FILT,
    parameter int RD_DELAY    = DEF_RD_DELAY
) (
    input logic              clk,
    input logic              rst_n,
    snes_bus_strobe_if.slave bus
);
    logic [NUM_LINES-1:0] w_raw, w_lvl, w_rise, w_fall;
    logic                 w_unused;

    assign w_raw    = {bus.SNES_RESET_in, bus.SNES_WRITE_in, bus.SNES_READ_in, bus.SNES_CPU_CLK_in};
    assign w_unused = ^{w_lvl[LN_CLK], w_lvl[LN_RD], w_fall[LN_CLK], w_fall[LN_RST]};

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        snes_sig_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT       (FILT),
            .RST_VAL    (LINE_RST[g])
        ) u_filt (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_raw  (w_raw[g]),
            .o_level(w_lvl[g]),
            .o_rise (w_rise[g]),
            .o_fall (w_fall[g])
        );
    end

    logic [23:0] r_addr_m, r_addr_q, r_addr;
    logic [7:0]  r_pa_m, r_pa_q, r_pa;
    logic [7:0]  r_data_m, r_data_q, r_data;
    rd_state_e   r_rd_st;
    logic [2:0]  r_dly;
    logic        r_rd_strobe, r_wr_strobe, r_cyc_start, r_rst_strobe;
    logic        r_ajr, r_pad, r_arm;
    logic        w_rst_act, w_rd_go, w_wr_go, w_wr_busy;

    assign w_rst_act = !w_lvl[LN_RST];
    assign w_rd_go   = !w_rst_act &&
                       (((r_rd_st == RD_IDLE) && w_fall[LN_RD] && (RD_DELAY == 0)) ||
                        ((r_rd_st == RD_WAIT) && !w_rise[LN_RD] && (r_dly == 3'd1)));
    // Sample while /WR is low; on the rise clock hold the last in-write sample.
    assign w_wr_busy = (!w_lvl[LN_WR] || w_fall[LN_WR]) && !w_rise[LN_WR];
    assign w_wr_go   = w_rise[LN_WR] && !w_rst_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_m     <= '0;
            r_addr_q     <= '0;
            r_addr       <= '0;
            r_pa_m       <= '0;
            r_pa_q       <= '0;
            r_pa         <= '0;
            r_data_m     <= '0;
            r_data_q     <= '0;
            r_data       <= '0;
            r_wr_strobe  <= 1'b0;
            r_cyc_start  <= 1'b0;
            r_rst_strobe <= 1'b0;
        end else begin
            r_addr_m     <= bus.SNES_ADDR_in;
            r_addr_q     <= r_addr_m;
            r_pa_m       <= bus.SNES_PA_in;
            r_pa_q       <= r_pa_m;
            r_data_m     <= bus.SNES_DATA_in;
            r_data_q     <= r_data_m;
            if (w_rd_go || w_wr_busy || (w_rise[LN_CLK] && !w_rise[LN_WR])) begin
                r_addr <= r_addr_q;
                r_pa   <= r_pa_q;
            end
            if (w_wr_busy) r_data <= r_data_q;
            r_wr_strobe  <= w_wr_go;
            r_cyc_start  <= w_rise[LN_CLK];
            r_rst_strobe <= w_rise[LN_RST];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_st     <= RD_IDLE;
            r_dly       <= '0;
            r_rd_strobe <= 1'b0;
        end else begin
            r_rd_strobe <= w_rd_go;
            if (w_rst_act) begin
                r_rd_st <= RD_IDLE;
                r_dly   <= '0;
            end else begin
                case (r_rd_st)
                    RD_IDLE: if (w_fall[LN_RD]) begin
                        r_rd_st <= (RD_DELAY == 0) ? RD_DONE : RD_WAIT;
                        r_dly   <= 3'(RD_DELAY);
                    end
                    RD_WAIT: begin
                        if (w_rise[LN_RD]) r_rd_st <= RD_IDLE;
                        else if (w_rd_go) r_rd_st <= RD_DONE;
                        else r_dly <= r_dly - 3'd1;
                    end
                    RD_DONE: if (w_rise[LN_RD]) r_rd_st <= RD_IDLE;
                    default: r_rd_st <= RD_IDLE;
                endcase
            end
        end
    end

    // Decode runs off the registered strobe, so status lags it by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ajr <= 1'b0;
            r_pad <= 1'b0;
            r_arm <= 1'b0;
        end else if (w_rise[LN_RST]) begin
            r_ajr <= 1'b0;
            r_pad <= 1'b0;
            r_arm <= 1'b0;
        end else if (r_wr_strobe) begin
            if (is_sys_reg(r_addr, SNES_REG_NMITIMEN)) r_ajr <= r_data[0];
            if (is_sys_reg(r_addr, SNES_REG_JOYSER0)) begin
                if (r_data[0]) begin
                    r_arm <= 1'b1;
                end else if (r_arm) begin
                    r_pad <= 1'b1;
                    r_arm <= 1'b0;
                end
            end
        end
    end

    assign bus.SNES_ADDR         = r_addr;
    assign bus.SNES_PA           = r_pa;
    assign bus.SNES_DATA         = r_data;
    assign bus.SNES_rd_strobe    = r_rd_strobe;
    assign bus.SNES_wr_strobe    = r_wr_strobe;
    assign bus.SNES_cycle_start  = r_cyc_start;
    assign bus.SNES_reset_strobe = r_rst_strobe;
    assign bus.SNES_reset_active = w_rst_act;
    assign bus.pad_latch         = r_pad;
    assign bus.snes_ajr          = r_ajr;
endmodule

// File: tb/tb_snes_bus_strobe.sv
// Scoreboard bench: stimulus queues expected strobes (cycle + captured values), a monitor pops them.
module tb_snes_bus_strobe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   slow_rd = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    snes_bus_strobe_if bus ();
    snes_bus_strobe_if bus2 ();

    assign bus2.SNES_CPU_CLK_in = bus.SNES_CPU_CLK_in;
    assign bus2.SNES_READ_in    = bus.SNES_READ_in;
    assign bus2.SNES_WRITE_in   = bus.SNES_WRITE_in;
    assign bus2.SNES_RESET_in   = bus.SNES_RESET_in;
    assign bus2.SNES_ADDR_in    = bus.SNES_ADDR_in;
    assign bus2.SNES_PA_in      = bus.SNES_PA_in;
    assign bus2.SNES_DATA_in    = bus.SNES_DATA_in;

    snes_bus_strobe dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    // Long read delay so a 6-clock /RD pulse ends while the FSM is still waiting.
    snes_bus_strobe #(.RD_DELAY(7)) dut_slow (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        int          cyc;
        logic [23:0] addr;
        logic [7:0]  pa;
        logic [7:0]  data;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];
    int   cs_q[$];
    int   rs_q[$];
    exp_t m_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic flag(input string nm, input int c);
        n_chk++;
        $display("FAIL %s: strobe event without match, expected cycle %0d, now %0d", nm, c, cyc);
    endtask

    always @(negedge clk) begin
        if (bus2.SNES_rd_strobe) slow_rd++;
        if (rst_n) begin
            if (bus.SNES_rd_strobe) begin
                if (rd_q.size() == 0) flag("rd_unexpected", -1);
                else begin
                    m_e = rd_q.pop_front();
                    chk("rd_cycle", cyc, m_e.cyc);
                    chk("rd_addr", 32'(bus.SNES_ADDR), 32'(m_e.addr));
                    chk("rd_pa", 32'(bus.SNES_PA), 32'(m_e.pa));
                end
            end else if (rd_q.size() != 0 && rd_q[0].cyc < cyc) begin
                flag("rd_missing", rd_q[0].cyc);
                void'(rd_q.pop_front());
            end
            if (bus.SNES_wr_strobe) begin
                if (wr_q.size() == 0) flag("wr_unexpected", -1);
                else begin
                    m_e = wr_q.pop_front();
                    chk("wr_cycle", cyc, m_e.cyc);
                    chk("wr_addr", 32'(bus.SNES_ADDR), 32'(m_e.addr));
                    chk("wr_pa", 32'(bus.SNES_PA), 32'(m_e.pa));
                    chk("wr_data", 32'(bus.SNES_DATA), 32'(m_e.data));
                end
            end else if (wr_q.size() != 0 && wr_q[0].cyc < cyc) begin
                flag("wr_missing", wr_q[0].cyc);
                void'(wr_q.pop_front());
            end
            if (bus.SNES_cycle_start) begin
                if (cs_q.size() == 0) flag("cs_unexpected", -1);
                else chk("cs_cycle", cyc, cs_q.pop_front());
            end else if (cs_q.size() != 0 && cs_q[0] < cyc) begin
                flag("cs_missing", cs_q[0]);
                void'(cs_q.pop_front());
            end
            if (bus.SNES_reset_strobe) begin
                if (rs_q.size() == 0) flag("rs_unexpected", -1);
                else begin
                    chk("rs_cycle", cyc, rs_q.pop_front());
                    chk("rs_ajr_clr", 32'(bus.snes_ajr), 32'd0);
                    chk("rs_pad_clr", 32'(bus.pad_latch), 32'd0);
                end
            end else if (rs_q.size() != 0 && rs_q[0] < cyc) begin
                flag("rs_missing", rs_q[0]);
                void'(rs_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_access(input logic [23:0] a, input int low, input bit expect_strobe);
        exp_t e;
        bus.SNES_ADDR_in = a;
        bus.SNES_PA_in   = 8'h00;
        tick(1);
        bus.SNES_READ_in = 1'b0;
        if (expect_strobe) begin
            e.cyc = cyc + 7; e.addr = a; e.pa = 8'h00; e.data = 8'h00;
            rd_q.push_back(e);
        end
        tick(low);
        bus.SNES_READ_in = 1'b1;
        tick(15);
    endtask

    task automatic wr_access(input logic [23:0] a, input logic [7:0] pa, input logic [7:0] d,
                             input bit expect_strobe);
        exp_t e;
        bus.SNES_ADDR_in = a;
        bus.SNES_PA_in   = pa;
        bus.SNES_DATA_in = d;
        tick(1);
        bus.SNES_WRITE_in = 1'b0;
        tick(6);
        bus.SNES_WRITE_in = 1'b1;
        if (expect_strobe) begin
            e.cyc = cyc + 5; e.addr = a; e.pa = pa; e.data = d;
            wr_q.push_back(e);
        end
        tick(12);
    endtask

    initial begin
        int s0;
        bus.SNES_CPU_CLK_in = 1'b0;
        bus.SNES_READ_in    = 1'b0;
        bus.SNES_WRITE_in   = 1'b1;
        bus.SNES_RESET_in   = 1'b1;
        bus.SNES_ADDR_in    = 24'h123456;
        bus.SNES_PA_in      = 8'h5A;
        bus.SNES_DATA_in    = 8'hA5;
        tick(4);
        chk("reset_addr", 32'(bus.SNES_ADDR), 32'd0);
        chk("reset_pa", 32'(bus.SNES_PA), 32'd0);
        chk("reset_data", 32'(bus.SNES_DATA), 32'd0);
        chk("reset_bits", 32'({bus.SNES_rd_strobe, bus.SNES_wr_strobe, bus.SNES_cycle_start,
                               bus.SNES_reset_strobe, bus.SNES_reset_active, bus.pad_latch,
                               bus.snes_ajr}), 32'd0);
        // Release with /RD already low: no read strobe may follow.
        rst_n = 1'b1;
        tick(20);
        bus.SNES_READ_in = 1'b1;
        tick(10);
        chk("release_slow_rd", slow_rd, 0);

        s0 = slow_rd;
        rd_access(24'h00FFEB, 20, 1'b1);
        chk("read_slow_count", slow_rd - s0, 1);
        rd_access(24'h00ABCD, 2, 1'b0);
        rd_access(24'h7E0010, 3, 1'b1);
        s0 = slow_rd;
        rd_access(24'h00C000, 6, 1'b1);
        chk("abort_slow_rd", slow_rd - s0, 0);

        wr_access(24'h004200, 8'h00, 8'h01, 1'b1);
        chk("ajr_set", 32'(bus.snes_ajr), 32'd1);
        wr_access(24'h004200, 8'h00, 8'h02, 1'b1);
        chk("ajr_bit0", 32'(bus.snes_ajr), 32'd0);
        wr_access(24'h404016, 8'h00, 8'h01, 1'b1);
        wr_access(24'h404016, 8'h00, 8'h00, 1'b1);
        chk("pad_bank40", 32'(bus.pad_latch), 32'd0);
        wr_access(24'h804016, 8'h00, 8'h00, 1'b1);
        chk("pad_unarmed", 32'(bus.pad_latch), 32'd0);
        wr_access(24'h804016, 8'h00, 8'h01, 1'b1);
        chk("pad_armed", 32'(bus.pad_latch), 32'd0);
        wr_access(24'h804016, 8'h00, 8'h00, 1'b1);
        chk("pad_latch", 32'(bus.pad_latch), 32'd1);
        wr_access(24'h004200, 8'h00, 8'h01, 1'b1);
        chk("ajr_reset_pre", 32'(bus.snes_ajr), 32'd1);

        bus.SNES_RESET_in = 1'b0;
        tick(10);
        chk("reset_active", 32'(bus.SNES_reset_active), 32'd1);
        rd_access(24'h00FFFC, 6, 1'b0);
        wr_access(24'h004200, 8'h00, 8'h00, 1'b0);
        bus.SNES_RESET_in = 1'b1;
        rs_q.push_back(cyc + 5);
        tick(10);
        chk("reset_inactive", 32'(bus.SNES_reset_active), 32'd0);
        chk("ajr_after_rst", 32'(bus.snes_ajr), 32'd0);
        chk("pad_after_rst", 32'(bus.pad_latch), 32'd0);

        fork
            begin
                repeat (6) begin
                    bus.SNES_CPU_CLK_in = 1'b1;
                    cs_q.push_back(cyc + 5);
                    tick(7);
                    bus.SNES_CPU_CLK_in = 1'b0;
                    tick(7);
                end
            end
            begin
                tick(2);
                wr_access(24'h7E21FF, 8'hFF, 8'h11, 1'b1);
                wr_access(24'h7E21FE, 8'hFE, 8'h22, 1'b1);
                wr_access(24'h7E21FD, 8'hFD, 8'h33, 1'b1);
                wr_access(24'h7E21FC, 8'hFC, 8'h44, 1'b1);
            end
        join
        tick(20);
        chk("rd_q_left", rd_q.size(), 0);
        chk("wr_q_left", wr_q.size(), 0);
        chk("cs_q_left", cs_q.size(), 0);
        chk("rs_q_left", rs_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
